// File: rtl/scan_misr_ctrl.sv
// Scan test session controller: streams patterns into NUM_CHAINS scan chains
// and compacts the chain scan-out into a MISR signature.
//
// state   | meaning
// IDLE    | waiting for start
// LOAD    | shift in first pattern; chain contents unknown, no compaction
// CAPTURE | single functional clock into the chains
// SHIFT   | shift in next pattern while compacting previous response
// UNLOAD  | flush the last response into the MISR
// DONE    | one-cycle completion pulse
module scan_misr_ctrl #(
    parameter int                NUM_CHAINS = 4,
    parameter int                CHAIN_LEN  = 8,
    parameter int                MISR_W     = 16,
    parameter logic [MISR_W-1:0] MISR_POLY  = 16'h1021,
    parameter logic [MISR_W-1:0] MISR_SEED  = '0
) (
    input  logic                  CK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  abort,
    input  logic [15:0]           num_pat,
    input  logic                  pat_valid,
    input  logic [NUM_CHAINS-1:0] pat_data,
    input  logic [NUM_CHAINS-1:0] so_in,
    output logic                  pat_ready,
    output logic                  scan_en,
    output logic                  chain_ce,
    output logic [NUM_CHAINS-1:0] si_out,
    output logic                  busy,
    output logic                  done,
    output logic [MISR_W-1:0]     signature
);
    localparam int            CW        = $clog2(CHAIN_LEN);
    localparam logic [CW-1:0] LAST_BEAT = CW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CAPTURE, S_SHIFT, S_UNLOAD, S_DONE
    } state_t;

    state_t            state, state_next;
    logic [CW-1:0]     shift_cnt;
    logic [15:0]       pat_cnt, num_pat_q;
    logic [MISR_W-1:0] sig, so_ext, sig_step;
    logic              arm, cnt_reload, cnt_step, pat_inc, sig_seed, sig_comp;

    always_comb begin
        so_ext = '0;
        so_ext[NUM_CHAINS-1:0] = so_in;
        sig_step = {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? MISR_POLY : '0) ^ so_ext;
    end

    always_comb begin
        state_next = state;
        pat_ready  = 1'b0;
        scan_en    = 1'b0;
        chain_ce   = 1'b0;
        si_out     = '0;
        arm        = 1'b0;
        cnt_reload = 1'b0;
        cnt_step   = 1'b0;
        pat_inc    = 1'b0;
        sig_seed   = 1'b0;
        sig_comp   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    sig_seed = 1'b1;
                    if (num_pat != 16'd0) begin
                        arm        = 1'b1;
                        cnt_reload = 1'b1;
                        state_next = S_LOAD;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_LOAD, S_SHIFT: begin
                pat_ready = 1'b1;
                scan_en   = 1'b1;
                chain_ce  = pat_valid;
                si_out    = pat_valid ? pat_data : '0;
                if (pat_valid) begin
                    cnt_step = 1'b1;
                    sig_comp = (state == S_SHIFT);
                    if (shift_cnt == '0) state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                chain_ce   = 1'b1;
                pat_inc    = 1'b1;
                cnt_reload = 1'b1;
                state_next = (pat_cnt == num_pat_q - 16'd1) ? S_UNLOAD : S_SHIFT;
            end
            S_UNLOAD: begin
                scan_en  = 1'b1;
                chain_ce = 1'b1;
                cnt_step = 1'b1;
                sig_comp = 1'b1;
                if (shift_cnt == '0) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // abort wins over every transition and freezes the signature
        if (abort && state != S_IDLE) begin
            state_next = S_IDLE;
            cnt_step   = 1'b0;
            cnt_reload = 1'b0;
            pat_inc    = 1'b0;
            sig_comp   = 1'b0;
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            shift_cnt <= '0;
            pat_cnt   <= '0;
            num_pat_q <= '0;
            sig       <= MISR_SEED;
        end else begin
            if (arm) begin
                num_pat_q <= num_pat;
                pat_cnt   <= '0;
            end else if (pat_inc) begin
                pat_cnt <= pat_cnt + 16'd1;
            end
            if (cnt_reload)
                shift_cnt <= LAST_BEAT;
            else if (cnt_step)
                shift_cnt <= (shift_cnt == '0) ? LAST_BEAT : shift_cnt - CW'(1);
            if (sig_seed)      sig <= MISR_SEED;
            else if (sig_comp) sig <= sig_step;
        end
    end

    assign signature = sig;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_scan_misr_ctrl.sv
// Bench for scan_misr_ctrl: default instance plus an 8-chain/3-flop/8-bit MISR
// instance, checked each cycle against a slot-sequence model of a session.
module tb_scan_misr_ctrl;
    localparam int K_IDLE = 0, K_LOAD = 1, K_CAP = 2, K_SHIFT = 3, K_UNL = 4, K_DONE = 5;

    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  start_v = '0;
    logic [1:0]  abort_v = '0;
    logic [15:0] num_pat = '0;
    logic        pat_valid = 1'b0;
    logic [7:0]  pat_data = '0;
    logic [7:0]  so_in = '0;
    int          vmode = 0;
    int          so_mode = 0;
    int          checks = 0;
    int          errors = 0;

    logic        pr1, se1, ce1, bz1, dn1;
    logic [3:0]  si1;
    logic [15:0] sg1;
    logic        pr2, se2, ce2, bz2, dn2;
    logic [7:0]  si2;
    logic [7:0]  sg2;

    int          m_act[2], m_pos[2], m_np[2];
    logic [15:0] m_sig[2];
    int          done_cnt[2], cap_cnt[2], se_seen[2];
    bit          rst_seen = 1'b0;

    always #5 CK = ~CK;

    scan_misr_ctrl dut1 (
        .CK(CK), .RST(RST), .start(start_v[0]), .abort(abort_v[0]), .num_pat(num_pat),
        .pat_valid(pat_valid), .pat_data(pat_data[3:0]), .so_in(so_in[3:0]),
        .pat_ready(pr1), .scan_en(se1), .chain_ce(ce1), .si_out(si1),
        .busy(bz1), .done(dn1), .signature(sg1)
    );

    scan_misr_ctrl #(.NUM_CHAINS(8), .CHAIN_LEN(3), .MISR_W(8), .MISR_POLY(8'h1D), .MISR_SEED(8'h00)) dut2 (
        .CK(CK), .RST(RST), .start(start_v[1]), .abort(abort_v[1]), .num_pat(num_pat),
        .pat_valid(pat_valid), .pat_data(pat_data), .so_in(so_in),
        .pat_ready(pr2), .scan_en(se2), .chain_ce(ce2), .si_out(si2),
        .busy(bz2), .done(dn2), .signature(sg2)
    );

    function automatic int cl_of(input int i);
        return (i == 0) ? 8 : 3;
    endfunction

    function automatic logic [15:0] ch_mask(input int i);
        return (i == 0) ? 16'h000F : 16'h00FF;
    endfunction

    function automatic logic [15:0] misr_step(input int i, input logic [15:0] s, input logic [7:0] so);
        int          w;
        logic [15:0] poly, mask, r;
        w    = (i == 0) ? 16 : 8;
        poly = (i == 0) ? 16'h1021 : 16'h001D;
        mask = (i == 0) ? 16'hFFFF : 16'h00FF;
        r    = (s << 1) & mask;
        if (s[w-1]) r = r ^ poly;
        return r ^ ({8'h00, so} & ch_mask(i));
    endfunction

    // a session is num_pat groups of (CHAIN_LEN beats, capture), then CHAIN_LEN unload cycles, then done
    function automatic int kind_of(input int pos, input int np, input int cl);
        int per;
        per = cl + 1;
        if (pos < np * per) begin
            if ((pos % per) == cl) return K_CAP;
            return (pos < per) ? K_LOAD : K_SHIFT;
        end
        if (pos < np * per + ((np > 0) ? cl : 0)) return K_UNL;
        return K_DONE;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0;
            m_pos[i] = 0;
            m_np[i]  = 0;
            m_sig[i] = '0;
        end
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d at %0t: got %0h, expected %0h", name, i, $time, act, exp);
        end
    endtask

    task automatic get_out(input int i, output logic pr, output logic se, output logic ce,
                           output logic bz, output logic dn, output logic [7:0] si, output logic [15:0] sg);
        if (i == 0) begin
            pr = pr1; se = se1; ce = ce1; bz = bz1; dn = dn1; si = {4'h0, si1}; sg = sg1;
        end else begin
            pr = pr2; se = se2; ce = ce2; bz = bz2; dn = dn2; si = si2; sg = {8'h00, sg2};
        end
    endtask

    function automatic logic done_of(input int i);
        return (i == 0) ? dn1 : dn2;
    endfunction

    always @(posedge RST) rst_seen = 1'b1;

    initial begin
        pat_valid = 1'b0;
        forever begin
            @(posedge CK);
            #1;
            if (vmode == 0) pat_valid = 1'b1;
            else            pat_valid = ~pat_valid;
            pat_data = 8'($urandom);
            so_in    = (so_mode == 0) ? 8'hFF : 8'($urandom);
        end
    end

    initial begin
        logic        pr, se, ce, bz, dn, beat;
        logic [7:0]  si;
        logic [15:0] sg, e_si;
        int          k;
        model_reset();
        forever begin
            @(negedge CK);
            if (RST || rst_seen) begin
                model_reset();
                if (!RST) rst_seen = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                get_out(i, pr, se, ce, bz, dn, si, sg);
                k    = (m_act[i] != 0) ? kind_of(m_pos[i], m_np[i], cl_of(i)) : K_IDLE;
                beat = (k == K_LOAD) || (k == K_SHIFT);
                e_si = (beat && pat_valid) ? ({8'h00, pat_data} & ch_mask(i)) : 16'h0000;
                chk("busy", i, 32'(bz), 32'(m_act[i] != 0));
                chk("done", i, 32'(dn), 32'(k == K_DONE));
                chk("pat_ready", i, 32'(pr), 32'(beat));
                chk("scan_en", i, 32'(se), 32'(beat || k == K_UNL));
                chk("chain_ce", i, 32'(ce), 32'(beat ? pat_valid : (k == K_CAP || k == K_UNL)));
                chk("si_out", i, 32'(si), 32'(e_si));
                chk("signature", i, 32'(sg), 32'(m_sig[i]));
                if (dn) done_cnt[i]++;
                if (bz && ce && !se) cap_cnt[i]++;
                if (se) se_seen[i] = 1;
            end
            @(posedge CK);
            if (RST || rst_seen) begin
                model_reset();
                if (!RST) rst_seen = 1'b0;
            end
            if (!RST) begin
                for (int i = 0; i < 2; i++) begin
                    if (m_act[i] == 0) begin
                        if (start_v[i]) begin
                            m_act[i] = 1;
                            m_pos[i] = 0;
                            m_np[i]  = int'(num_pat);
                            m_sig[i] = '0;
                        end
                    end else if (abort_v[i]) begin
                        m_act[i] = 0;
                    end else begin
                        k = kind_of(m_pos[i], m_np[i], cl_of(i));
                        case (k)
                            K_LOAD:  if (pat_valid) m_pos[i]++;
                            K_SHIFT: if (pat_valid) begin
                                m_sig[i] = misr_step(i, m_sig[i], so_in);
                                m_pos[i]++;
                            end
                            K_CAP:   m_pos[i]++;
                            K_UNL: begin
                                m_sig[i] = misr_step(i, m_sig[i], so_in);
                                m_pos[i]++;
                            end
                            default: m_act[i] = 0;
                        endcase
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            done_cnt[i] = 0;
            cap_cnt[i]  = 0;
            se_seen[i]  = 0;
        end
    endtask

    task automatic start_session(input int i, input logic [15:0] np);
        num_pat    = np;
        start_v[i] = 1'b1;
        tick();
        start_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int n);
        n = 1;
        @(negedge CK);
        while (!done_of(i) && n < 500) begin
            @(negedge CK);
            n++;
        end
        chk("done_seen", i, 32'(done_of(i)), 32'd1);
    endtask

    initial begin
        int n;
        #2;
        chk("rst_busy", 0, 32'(bz1), 32'd0);
        chk("rst_done", 0, 32'(dn1), 32'd0);
        chk("rst_scan_en", 0, 32'(se1), 32'd0);
        chk("rst_chain_ce", 0, 32'(ce1), 32'd0);
        chk("rst_pat_ready", 0, 32'(pr1), 32'd0);
        chk("rst_si_out", 0, 32'(si1), 32'd0);
        chk("rst_signature", 0, 32'(sg1), 32'd0);
        chk("rst_signature", 1, 32'(sg2), 32'd0);
        repeat (2) @(posedge CK);
        #1;
        RST = 1'b0;
        tick();

        // single pattern, continuous valid, all-ones scan-out
        vmode = 0; so_mode = 0;
        tick();
        clear_counts();
        start_session(0, 16'd1);
        wait_done(0, n);
        chk("a_cycles_to_done", 0, 32'(n), 32'd18);
        chk("a_signature", 0, 32'(sg1), 32'h0505);
        tick();
        chk("a_done_pulses", 0, 32'(done_cnt[0]), 32'd1);
        chk("a_captures", 0, 32'(cap_cnt[0]), 32'd1);

        // three patterns with a stall every other cycle
        vmode = 1; so_mode = 1;
        clear_counts();
        start_session(0, 16'd3);
        wait_done(0, n);
        repeat (3) tick();
        chk("b_done_pulses", 0, 32'(done_cnt[0]), 32'd1);
        chk("b_captures", 0, 32'(cap_cnt[0]), 32'd3);

        // zero patterns
        vmode = 0; so_mode = 1;
        tick();
        clear_counts();
        start_session(0, 16'd0);
        @(negedge CK);
        chk("c_done", 0, 32'(dn1), 32'd1);
        chk("c_signature", 0, 32'(sg1), 32'd0);
        tick();
        tick();
        chk("c_scan_en_seen", 0, 32'(se_seen[0]), 32'd0);
        chk("c_done_pulses", 0, 32'(done_cnt[0]), 32'd1);

        // abort on the 4th shift beat of the second pattern
        clear_counts();
        start_session(0, 16'd3);
        repeat (12) tick();
        @(negedge CK);
        chk("d_in_shift", 0, 32'(pr1), 32'd1);
        abort_v[0] = 1'b1;
        tick();
        abort_v[0] = 1'b0;
        @(negedge CK);
        chk("d_busy_after_abort", 0, 32'(bz1), 32'd0);
        chk("d_scan_en_after_abort", 0, 32'(se1), 32'd0);
        chk("d_chain_ce_after_abort", 0, 32'(ce1), 32'd0);
        repeat (5) tick();
        chk("d_no_done", 0, 32'(done_cnt[0]), 32'd0);
        so_mode = 0;
        clear_counts();
        start_session(0, 16'd1);
        wait_done(0, n);
        chk("d_rerun_cycles", 0, 32'(n), 32'd18);
        chk("d_rerun_signature", 0, 32'(sg1), 32'h0505);
        tick();
        chk("d_rerun_done_pulses", 0, 32'(done_cnt[0]), 32'd1);

        // asynchronous reset in the middle of unload
        clear_counts();
        start_session(0, 16'd1);
        repeat (10) tick();
        @(negedge CK);
        chk("e_in_unload", 0, 32'({se1, pr1}), 32'b10);
        @(posedge CK);
        #3;
        RST = 1'b1;
        #1;
        chk("e_rst_busy", 0, 32'(bz1), 32'd0);
        chk("e_rst_scan_en", 0, 32'(se1), 32'd0);
        chk("e_rst_chain_ce", 0, 32'(ce1), 32'd0);
        chk("e_rst_done", 0, 32'(dn1), 32'd0);
        chk("e_rst_signature", 0, 32'(sg1), 32'd0);
        #2;
        RST = 1'b0;
        repeat (25) tick();
        chk("e_no_done", 0, 32'(done_cnt[0]), 32'd0);
        chk("e_idle", 0, 32'(bz1), 32'd0);

        // 8 chains of 3 flops, 8-bit MISR
        vmode = 0; so_mode = 0;
        clear_counts();
        start_session(1, 16'd2);
        wait_done(1, n);
        chk("f_cycles_to_done", 1, 32'(n), 32'd12);
        chk("f_signature", 1, 32'(sg2), 32'hB1);
        tick();
        chk("f_done_pulses", 1, 32'(done_cnt[1]), 32'd1);
        chk("f_captures", 1, 32'(cap_cnt[1]), 32'd2);
        vmode = 1; so_mode = 1;
        clear_counts();
        start_session(1, 16'd2);
        wait_done(1, n);
        tick();
        chk("f_stall_done_pulses", 1, 32'(done_cnt[1]), 32'd1);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_misr_ctrl.md
SCAN_MISR_CTRL -- requirements
Module: scan_misr_ctrl

Interface
REQ-001 SHALL have parameter NUM_CHAINS, default 4: number of parallel scan chains driven and observed.
REQ-002 SHALL have parameter CHAIN_LEN, default 8: flops per chain (≥2).
REQ-003 SHALL have parameter MISR_W, default 16: signature width (≥ NUM_CHAINS).
REQ-004 SHALL have parameter MISR_POLY, default 16'h1021: feedback taps.
REQ-005 SHALL have parameter MISR_SEED, default 0: signature value loaded at reset/start.
REQ-006 SHALL have port CK  input  1  single clock, rising edge.
REQ-007 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port start  input  1  begin test session (sampled in IDLE only).
REQ-009 SHALL have port abort  input  1  synchronous return to IDLE, no done.
REQ-010 SHALL have port num_pat  input  16  pattern count, sampled on accepted start.
REQ-011 SHALL have port pat_valid  input  1  pat_data valid this cycle.
REQ-012 SHALL have port pat_data  input  NUM_CHAINS  one scan-in bit per chain.
REQ-013 SHALL have port so_in  input  NUM_CHAINS  scan-out bit of each DUT chain.
REQ-014 SHALL have port pat_ready  output  1  beat accepted when pat_valid & pat_ready.
REQ-015 SHALL have port scan_en  output  1  DUT scan-mux select (1 = shift).
REQ-016 SHALL have port chain_ce  output  1  DUT scan flop clock enable.
REQ-017 SHALL have port si_out  output  NUM_CHAINS  scan-in bits to DUT chains.
REQ-018 SHALL have port busy  output  1  high in any state except IDLE.
REQ-019 SHALL have port done  output  1  one-cycle completion pulse.
REQ-020 SHALL have port signature  output  MISR_W  MISR contents.

Function
REQ-021 SHALL implement states IDLE, LOAD, CAPTURE, SHIFT, UNLOAD, DONE.
REQ-022 IDLE: start=1 and num_pat≠0 -> LOAD; start=1 and num_pat=0 -> DONE; signature <= MISR_SEED on any accepted start; start while busy ignored.
REQ-023 LOAD/SHIFT: pat_ready=1, scan_en=1; chain_ce = pat_valid; si_out = pat_data when pat_valid else 0; shift counter advances only on accepted beats.
REQ-024 LOAD: CHAIN_LEN accepted beats -> CAPTURE; no compaction (chains hold unknown data).
REQ-025 CAPTURE: exactly one cycle, scan_en=0, chain_ce=1, pat_ready=0; pattern counter increments; -> SHIFT if patterns captured < num_pat, else -> UNLOAD.
REQ-026 SHIFT: on every accepted beat MISR compacts so_in; after CHAIN_LEN beats -> CAPTURE.
REQ-027 UNLOAD: CHAIN_LEN consecutive cycles, scan_en=1, chain_ce=1, si_out=0, pat_ready=0, MISR compacts every cycle; then -> DONE.
REQ-028 DONE: done=1 one cycle, signature held; -> IDLE.
REQ-029 MISR update SHALL be sig <= {sig[MISR_W-2:0],1'b0} ^ (sig[MISR_W-1] ? MISR_POLY : 0) ^ zero-extended so_in.
REQ-030 signature SHALL hold its value outside compacting cycles, including stall cycles (pat_valid=0).
REQ-031 abort=1 in any busy state SHALL force IDLE next cycle, scan_en=0, chain_ce=0, done never asserted, signature held; abort in IDLE has no effect; abort has priority over all transitions.
REQ-032 In IDLE and DONE: scan_en=0, chain_ce=0, pat_ready=0, si_out=0.
REQ-033 Outputs scan_en, chain_ce, pat_ready, si_out SHALL be combinational from state and pat_valid/pat_data only; no other comb path from inputs to outputs.
REQ-034 Shift counter SHALL be $clog2(CHAIN_LEN) bits minimum; pattern counter 16 bits; num_pat=16'hFFFF SHALL run 65535 patterns with no wrap.

Reset
REQ-035 RST=1 SHALL asynchronously force IDLE, counters 0, signature=MISR_SEED, done=0, busy=0, scan_en=0, chain_ce=0, pat_ready=0, si_out=0.
REQ-036 RST asserted mid-session SHALL discard the session; no done pulse after release.

Verification
REQ-037 Defaults, num_pat=1, pat_valid always 1, so_in=4'hF during UNLOAD -> 8 LOAD, 1 CAPTURE, 8 UNLOAD cycles, done on cycle 18 after start, signature equals MISR reference model.
REQ-038 num_pat=3 with pat_valid deasserted every other cycle -> chain_ce follows pat_valid, signature unchanged on stall cycles, exactly 3 CAPTURE cycles, single done.
REQ-039 start with num_pat=0 -> done one cycle later, signature=MISR_SEED, scan_en never 1.
REQ-040 abort during 4th SHIFT beat of pattern 2 -> IDLE next cycle, busy=0, no done, later start runs cleanly from MISR_SEED.
REQ-041 RST pulsed mid-UNLOAD (between clock edges) -> outputs reset immediately without a clock edge, signature=MISR_SEED.
REQ-042 NUM_CHAINS=8, CHAIN_LEN=3, MISR_W=8, POLY=8'h1D, num_pat=2 -> chain length counting and MISR width match reference model.
